// File: rtl/cp0.sv
// Coprocessor 0: status, cause, EPC and PRId registers, interrupt and
// exception arbitration, and the trap request to the PC logic.
module cp0 (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] PC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic        EXLClr,
    input  logic [5:0]  HWInt,
    output logic        Req,
    output logic [31:0] EPCOut,
    output logic [31:0] DOut
);

    localparam logic [31:0] PRID = 32'h0000_0707;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic [31:0] sr_val;
    logic [31:0] cause_val;
    logic [31:0] trap_epc;

    assign int_req = ie & ~exl & (|(HWInt & im));
    assign exc_req = ~exl & (ExcCodeIn != 5'd0);
    assign Req     = int_req | exc_req;

    // A delay-slot instruction must restart at its branch.
    assign trap_epc = BDIn ? (PC - 32'd4) : PC;

    assign sr_val    = {16'd0, im, 8'd0, exl, ie};
    assign cause_val = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};

    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= 6'd0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= 6'd0;
            exc_code <= 5'd0;
            epc      <= 32'd0;
        end else begin
            ip <= HWInt;
            if (Req) begin
                exl      <= 1'b1;
                exc_code <= int_req ? 5'd0 : ExcCodeIn;
                bd       <= BDIn;
                epc      <= trap_epc;
            end else begin
                if (WE) begin
                    case (A2)
                        REG_SR: begin
                            im  <= DIn[15:10];
                            exl <= DIn[1];
                            ie  <= DIn[0];
                        end
                        REG_EPC: epc <= DIn;
                        default: ;
                    endcase
                end
                // eret wins over a simultaneous mtc0 on EXL only.
                if (EXLClr) begin
                    exl <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        DOut = 32'd0;
        case (A1)
            REG_SR:    DOut = sr_val;
            REG_CAUSE: DOut = cause_val;
            REG_EPC:   DOut = epc;
            REG_PRID:  DOut = PRID;
            default:   DOut = 32'd0;
        endcase
    end

    assign EPCOut = (WE && (A2 == REG_EPC)) ? DIn : epc;

endmodule

// File: tb/tb_cp0.sv
// Vector table and scoreboard bench for cp0.
module tb_cp0;

    logic        clk;
    logic        reset;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] PC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic        EXLClr;
    logic [5:0]  HWInt;
    logic        Req;
    logic [31:0] EPCOut;
    logic [31:0] DOut;

    cp0 dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
        .PC(PC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .EXLClr(EXLClr),
        .HWInt(HWInt), .Req(Req), .EPCOut(EPCOut), .DOut(DOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [4:0]  a1;
        logic        we;
        logic [4:0]  a2;
        logic [31:0] din;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
        logic        eret;
        logic [5:0]  hw;
        logic        req;
        logic [31:0] dout;
        logic [31:0] epco;
    } vec_t;

    typedef struct {
        int          idx;
        logic        req;
        logic [31:0] dout;
        logic [31:0] epco;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_chk;
    int   n_fail;
    int   vidx;

    function automatic vec_t mk(
        input logic rst, input logic [4:0] a1, input logic we,
        input logic [4:0] a2, input logic [31:0] din, input logic [31:0] pc,
        input logic bd, input logic [4:0] exc, input logic eret,
        input logic [5:0] hw, input logic req, input logic [31:0] dout,
        input logic [31:0] epco);
        vec_t v;
        v.rst = rst; v.a1 = a1; v.we = we; v.a2 = a2; v.din = din;
        v.pc = pc; v.bd = bd; v.exc = exc; v.eret = eret; v.hw = hw;
        v.req = req; v.dout = dout; v.epco = epco;
        return v;
    endfunction

    task automatic chk(input string nm, input int i,
                       input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h want %h", nm, i, got, want);
        end
    endtask

    // Drive one vector, queue its expectations, compare before the edge.
    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        reset = v.rst; A1 = v.a1; WE = v.we; A2 = v.a2; DIn = v.din;
        PC = v.pc; BDIn = v.bd; ExcCodeIn = v.exc; EXLClr = v.eret;
        HWInt = v.hw;
        e.idx = vidx; e.req = v.req; e.dout = v.dout; e.epco = v.epco;
        sb.push_back(e);
        vidx++;
        #1;
        if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL scoreboard_empty vec %0d", vidx);
        end else begin
            e = sb.pop_front();
            chk("Req", e.idx, {31'd0, Req}, {31'd0, e.req});
            chk("DOut", e.idx, DOut, e.dout);
            chk("EPCOut", e.idx, EPCOut, e.epco);
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0; vidx = 0;
        reset = 1'b1; A1 = 5'd12; A2 = 5'd0; DIn = 32'd0; WE = 1'b0;
        PC = 32'd0; BDIn = 1'b0; ExcCodeIn = 5'd0; EXLClr = 1'b0;
        HWInt = 6'd0;
        repeat (2) @(posedge clk);

        //          rst a1  we a2  din           pc            bd exc eret hw  req dout          epco
        tbl.push_back(mk(0, 13, 0, 0, 0,           0,            0, 0,  0, 0, 0, 32'h0,        32'h0));
        tbl.push_back(mk(0, 14, 0, 0, 0,           0,            0, 0,  0, 0, 0, 32'h0,        32'h0));
        tbl.push_back(mk(0, 15, 0, 0, 0,           0,            0, 0,  0, 0, 0, 32'h707,      32'h0));
        tbl.push_back(mk(0, 12, 0, 0, 0,           0,            0, 0,  0, 1, 0, 32'h0,        32'h0));
        tbl.push_back(mk(0, 13, 1, 12, 32'h401,    0,            0, 0,  0, 1, 0, 32'h400,      32'h0));
        tbl.push_back(mk(0, 12, 0, 0, 0,           32'h3010,     0, 0,  0, 1, 1, 32'h401,      32'h0));
        tbl.push_back(mk(0, 14, 0, 0, 0,           0,            0, 0,  0, 1, 0, 32'h3010,     32'h3010));
        tbl.push_back(mk(0, 13, 0, 0, 0,           0,            0, 0,  0, 1, 0, 32'h400,      32'h3010));
        tbl.push_back(mk(0, 12, 0, 0, 0,           0,            0, 0,  0, 1, 0, 32'h403,      32'h3010));
        tbl.push_back(mk(0, 12, 0, 0, 0,           0,            0, 0,  1, 0, 0, 32'h403,      32'h3010));
        tbl.push_back(mk(0, 13, 0, 0, 0,           32'h3020,     1, 4,  0, 0, 1, 32'h0,        32'h3010));
        tbl.push_back(mk(0, 13, 0, 0, 0,           0,            0, 0,  0, 0, 0, 32'h8000_0010, 32'h301C));
        tbl.push_back(mk(0, 14, 0, 0, 0,           0,            0, 4,  0, 0, 0, 32'h301C,     32'h301C));
        tbl.push_back(mk(0, 12, 0, 0, 0,           0,            0, 0,  1, 0, 0, 32'h403,      32'h301C));
        tbl.push_back(mk(0, 12, 0, 0, 0,           32'h3040,     0, 10, 0, 1, 1, 32'h401,      32'h301C));
        tbl.push_back(mk(0, 13, 0, 0, 0,           0,            0, 0,  0, 1, 0, 32'h400,      32'h3040));
        tbl.push_back(mk(0, 12, 0, 0, 0,           0,            0, 0,  1, 1, 0, 32'h403,      32'h3040));
        tbl.push_back(mk(0, 12, 0, 0, 0,           32'h3050,     0, 0,  0, 1, 1, 32'h401,      32'h3040));
        tbl.push_back(mk(0, 14, 1, 14, 32'h4000,   0,            0, 0,  0, 0, 0, 32'h3050,     32'h4000));
        tbl.push_back(mk(0, 14, 1, 13, 32'hFFFF_FFFF, 0,         0, 0,  0, 0, 0, 32'h4000,     32'h4000));
        tbl.push_back(mk(0, 13, 0, 0, 0,           0,            0, 0,  0, 0, 0, 32'h0,        32'h4000));
        tbl.push_back(mk(0, 12, 0, 0, 0,           0,            0, 0,  1, 0, 0, 32'h403,      32'h4000));
        tbl.push_back(mk(0, 12, 1, 12, 32'h0,      32'h3060,     0, 0,  0, 1, 1, 32'h401,      32'h4000));
        tbl.push_back(mk(0, 12, 0, 0, 0,           0,            0, 0,  0, 0, 0, 32'h403,      32'h3060));
        tbl.push_back(mk(0, 12, 1, 12, 32'h1,      0,            0, 0,  0, 0, 0, 32'h403,      32'h3060));
        tbl.push_back(mk(0, 12, 0, 0, 0,           0,            0, 0,  0, 7, 0, 32'h1,        32'h3060));
        tbl.push_back(mk(0, 13, 0, 0, 0,           0,            0, 0,  0, 7, 0, 32'h1C00,     32'h3060));
        tbl.push_back(mk(0, 13, 0, 0, 0,           32'h0,        1, 12, 0, 0, 1, 32'h1C00,     32'h3060));
        tbl.push_back(mk(0, 14, 0, 0, 0,           0,            0, 0,  0, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC));
        tbl.push_back(mk(0, 13, 0, 0, 0,           0,            0, 0,  0, 0, 0, 32'h8000_0030, 32'hFFFF_FFFC));
        tbl.push_back(mk(0, 7,  1, 7, 32'h1234,    0,            0, 0,  0, 0, 0, 32'h0,        32'hFFFF_FFFC));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // Reset while EXL=1, then an exception taken straight after reset.
        apply(mk(1, 12, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h3, 32'hFFFF_FFFC));
        apply(mk(0, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0));
        apply(mk(0, 12, 0, 0, 0, 32'h100, 0, 8, 0, 0, 1, 32'h0, 32'h0));
        apply(mk(0, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h20, 32'h100));

        if (sb.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL scoreboard_left got %0d want 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0.md
# cp0

Coprocessor 0 of the five-stage MIPS core: holds SR, Cause, EPC and PRId, samples the six hardware interrupt lines (Timer0, Timer1, external device) and the exception code arriving with the memory-stage instruction, and decides each cycle whether the pipeline must trap. It sits directly downstream of the timers' IRQ outputs and beside the memory stage. It supplies the flush/redirect request and the EPC value to the PC logic. It also serves mfc0/mtc0/eret.

## Interface
- PRID, 32'h0000_0707, constant returned when reading register 15

- clk  in  1  system clock
- reset  in  1  synchronous, active-high; all registers cleared on the rising edge where reset=1
- A1  in  5  mfc0 read register number
- A2  in  5  mtc0 write register number
- DIn  in  32  mtc0 write data
- WE  in  1  mtc0 write enable (memory stage)
- PC  in  32  PC of the memory-stage instruction (macro-PC; a bubble carries the PC of the next real instruction)
- BDIn  in  1  memory-stage instruction is in a branch delay slot
- ExcCodeIn  in  5  exception code of memory-stage instruction, 0 = none
- EXLClr  in  1  eret in memory stage
- HWInt  in  6  [0]=Timer0 IRQ, [1]=Timer1 IRQ, [2]=external interrupt, [5:3]=tied 0
- Req  out  1  take interrupt/exception this cycle (flush, redirect to handler)
- EPCOut  out  32  return address for eret
- DOut  out  32  mfc0 read data

## Operation
- SR (reg 12): IM=[15:10], EXL=[1], IE=[0]; all other bits read 0.
- Cause (reg 13): BD=[31], IP=[15:10], ExcCode=[6:2]; other bits read 0. Not writable by mtc0.
- EPC (reg 14): 32 bits, writable. PRId (reg 15): reads PRID. Any other number reads 0; writes to it are ignored.
- IntReq = IE & ~EXL & |(HWInt & IM). ExcReq = ~EXL & (ExcCodeIn != 0). Req = IntReq | ExcReq. Interrupt has priority over exception.
- On an edge with Req=1:
  - EXL<=1.
  - ExcCode <= IntReq ? 0 : ExcCodeIn.
  - BD<=BDIn.
  - EPC <= BDIn ? PC-4 : PC (32-bit wrap, no carry out). PC-4 wrapping from 0 gives 32'hFFFF_FFFC.
- On every non-reset edge: IP<=HWInt, independent of Req and EXL.
- mtc0 (WE=1, Req=0):
  - A2=12 writes IM, EXL, IE from DIn.
  - A2=14 writes EPC=DIn.
  - Other numbers are ignored.
- eret (EXLClr=1, Req=0): EXL<=0.
- Same-edge priority: reset > Req > WE > EXLClr.
  - WE and EXLClr together do not occur; if they do, the mtc0 result applies to IM/IE and EXL<=0.
  - When Req=1, WE and EXLClr are ignored. The trapped instruction does not commit.
- DOut = register selected by A1. Combinational read of current register contents, no bypass.
- EPCOut: equals DIn when WE=1 and A2=14 in the same cycle; otherwise the EPC register. This supports mtc0 EPC directly followed by eret.
- Level-sensitive interrupts: a timer IRQ held high re-requests once EXL clears unless software masks it or services the timer.

## Timing
- Req, DOut and EPCOut are purely combinational from inputs and current state; no cycle of latency.
- Register updates take effect on the next rising clk edge. Interrupt masking by an mtc0 to SR is visible one cycle later.
- IP reflects HWInt with one cycle of delay.
- Reset values: SR=0, Cause=0, EPC=0.
  - Therefore Req=0 until IE and IM are set, except for a synchronous exception, which is accepted immediately after reset because EXL=0.
  - DOut follows A1 (0 for regs 12–14, PRID for 15).
  - EPCOut=0 unless the bypass applies.
- Reset asserted while EXL=1 clears EXL on that edge; pending IRQs are re-evaluated from the following cycle.
- While EXL=1, Req is 0 regardless of HWInt or ExcCodeIn. Nested traps are not supported.

## Test plan
- Reset, then A1=12,13,14,15 -> DOut = 0, 0, 0, 32'h0000_0707; Req=0 with HWInt=6'b000001.
- mtc0 SR=32'h0000_0401 (IM0, IE), then HWInt[0]=1 with PC=32'h0000_3010, BDIn=0 -> Req=1 that cycle. Next cycle:
  - EPC=32'h0000_3010, EXL=1, ExcCode=0.
  - Cause reads 32'h0000_0400.
  - Req=0 while IRQ is held.
- ExcCodeIn=5'd4, BDIn=1, PC=32'h0000_3020, HWInt=0 -> Req=1. Next cycle: EPC=32'h0000_301C, Cause=32'h8000_0010.
- Interrupt and exception in the same cycle (IM0, IE set, HWInt[0]=1, ExcCodeIn=10) -> ExcCode=0 recorded. Then:
  - eret (EXLClr=1) -> EXL=0 next cycle.
  - Req reasserts if HWInt[0] is still 1.
- Same-cycle WE=1, A2=14, DIn=32'h0000_4000 -> EPCOut=32'h0000_4000 combinationally; EPC holds it next cycle. mtc0 A2=13 leaves Cause unchanged.
- Req=1 coincident with WE=1, A2=12, DIn=0 -> write discarded (IE stays 1, EXL=1). IM=0 masks all interrupts; Req stays 0 with HWInt=6'b000111.
